serial_tx: RTL and testbench

//  Parallel-to-serial frame transmitter: accepts a DATA_W-bit word via valid/ready, emits it on one

---
 rtl/serial_tx_pkg.sv | 32 +++
 rtl/serial_tx_if.sv | 31 +++
 rtl/serial_tx_shreg.sv | 51 +++++
 rtl/serial_tx.sv | 209 ++++++++++++++++++++
 tb/tb_serial_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and line levels for the serial_tx frame transmitter.
//   tx_state_t : transmitter FSM states (PARITY exists only when
//                SERIAL_TX_PARITY_EN is defined)
//   LINE_IDLE  : level of the line between frames
//   START_LVL  : level of the start bit
//   STOP_LVL   : level of the stop bit(s)
//   cnt_width  : width of a counter that must hold the value n
// -----------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// -----------------------------------------------------------------------------
// serial_tx_if
// Load handshake between a word producer and the serial_tx transmitter.
//   data_in    : word to send, sampled only on the accept edge
//   load_valid : producer has a word
//   load_ready : transmitter can accept (accept = load_valid & load_ready)
// Modports:
//   master : producer side (drives data_in / load_valid)
//   slave  : transmitter side (drives load_ready)
// -----------------------------------------------------------------------------
interface serial_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_in;
  logic              load_valid;
  logic              load_ready;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/serial_tx_shreg.sv
// -----------------------------------------------------------------------------
// serial_tx_shreg
// Loadable shift register holding the word being serialised. Zeros are shifted
// in behind the data, so the register never wraps back onto the line.
// Ports:
//   clk        : rising-edge clock
//   reset_sync : synchronous active-high reset, clears the register
//   load_en    : load load_data (has priority over shift_en)
//   shift_en   : advance one bit toward the output end
//   load_data  : word to load
//   bit_out    : bit currently at the output end
// Parameters:
//   DATA_W     : register width
//   MSB_FIRST  : 0 = shift right, output bit 0; 1 = shift left, output MSB
// -----------------------------------------------------------------------------
module serial_tx_shreg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset_sync,
  input  logic              load_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] load_data,
  output logic              bit_out
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_q[DATA_W-2:0], 1'b0};
      assign bit_out = shreg_q[DATA_W-1];
    end else begin : g_lsb
      assign shifted = {1'b0, shreg_q[DATA_W-1:1]};
      assign bit_out = shreg_q[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      shreg_q <= '0;
    end else if (load_en) begin
      shreg_q <= load_data;
    end else if (shift_en) begin
      shreg_q <= shifted;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Parallel-to-serial frame transmitter. A DATA_W-bit word accepted over the
// load handshake is sent on ser_out as: start bit, data bits, optional even
// parity bit, STOP_BITS stop bits. Every bit lasts one tick_en period and the
// line only moves on clk edges where tick_en=1. The line idles high.
//
// Optional feature: define SERIAL_TX_PARITY_EN to insert one even-parity bit
// (XOR of the data word, captured at accept) between the data and stop bits.
//
// Ports:
//   clk        : rising-edge clock
//   reset_sync : synchronous active-high reset, overrides all inputs
//   tick_en    : bit-rate strobe
//   bus        : load handshake (slave modport: data_in, load_valid, load_ready)
//   ser_out    : registered serial line
//   busy       : high from the accept edge until the frame ends
//   done       : one-clk pulse after the last stop bit completes
// Parameters:
//   DATA_W     : data bits per frame (5..16)
//   STOP_BITS  : stop bits per frame (1 or 2)
//   MSB_FIRST  : 0 = LSB first, 1 = MSB first
// -----------------------------------------------------------------------------
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset_sync,
  input  logic        tick_en,
  serial_tx_if.slave  bus,
  output logic        ser_out,
  output logic        busy,
  output logic        done
);

  localparam int                CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W);
  localparam logic              STOP_END = 1'(STOP_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             ser_q, ser_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_stop;
  logic             load_en;
  logic             shift_en;
  logic             shift_bit;

  assign accept    = bus.load_valid & ready_q;
  assign last_stop = (stop_cnt_q == STOP_END);

  serial_tx_shreg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk        (clk),
    .reset_sync (reset_sync),
    .load_en    (load_en),
    .shift_en   (shift_en),
    .load_data  (bus.data_in),
    .bit_out    (shift_bit)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      parity_q <= 1'b0;
    end else if (load_en) begin
      parity_q <= ^bus.data_in;
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ser_q      <= LINE_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ser_q      <= ser_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)  state_d = ST_ARMED;
      // The accept edge never counts as a tick, so the start bit always
      // begins on a later tick edge and the frame stays tick-aligned.
      ST_ARMED: if (tick_en) state_d = ST_START;
      ST_START: if (tick_en) state_d = ST_DATA;
      ST_DATA: begin
        if (tick_en && (bit_cnt_q == BIT_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: if (tick_en) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick_en && last_stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    ser_d      = ser_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_en    = 1'b1;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (tick_en) ser_d = START_LVL;
      end
      ST_START: begin
        if (tick_en) begin
          ser_d     = shift_bit;
          shift_en  = 1'b1;
          bit_cnt_d = CNT_W'(1);
        end
      end
      ST_DATA: begin
        // bit_cnt counts data bits already on the line; once it reaches
        // DATA_W the current tick ends the last data bit.
        if (tick_en) begin
          if (bit_cnt_q < BIT_LAST) begin
            ser_d     = shift_bit;
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
`ifdef SERIAL_TX_PARITY_EN
            ser_d = parity_q;
`else
            ser_d = STOP_LVL;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_en) ser_d = STOP_LVL;
      end
`endif
      ST_STOP: begin
        if (tick_en) begin
          if (last_stop) begin
            ser_d   = LINE_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        ser_d   = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.load_ready = ready_q;
  assign ser_out        = ser_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
// Directed bench for serial_tx (DATA_W=8, STOP_BITS=1, LSB first). Frames are
// captured one bit per tick edge into a vector whose bit i is the i-th bit on
// the line (bit 0 = start bit) and compared against hand-computed constants.
// Build with SERIAL_TX_PARITY_EN defined to use the 11-bit parity frames.
// -----------------------------------------------------------------------------
module tb_serial_tx;

  localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
  // {stop, parity, data, start}, bit 0 transmitted first
  localparam logic [15:0] EXP_A5 = 16'h054A;
  localparam logic [15:0] EXP_00 = 16'h0400;
  localparam logic [15:0] EXP_FF = 16'h05FE;
  localparam logic [15:0] EXP_01 = 16'h0602;
  localparam logic [15:0] EXP_80 = 16'h0700;
  localparam logic [15:0] EXP_3C = 16'h0478;
  localparam logic [15:0] EXP_C3 = 16'h0586;
`else
  localparam int NBITS = 10;
  // {stop, data, start}, bit 0 transmitted first
  localparam logic [15:0] EXP_A5 = 16'h034A;
  localparam logic [15:0] EXP_00 = 16'h0200;
  localparam logic [15:0] EXP_FF = 16'h03FE;
  localparam logic [15:0] EXP_01 = 16'h0202;
  localparam logic [15:0] EXP_80 = 16'h0300;
  localparam logic [15:0] EXP_3C = 16'h0278;
  localparam logic [15:0] EXP_C3 = 16'h0386;
`endif

  logic clk = 1'b0;
  logic reset_sync = 1'b1;
  logic tick_en = 1'b0;
  logic ser_out;
  logic busy;
  logic done;

  serial_tx_if #(.DATA_W(DW)) bus ();

  serial_tx #(
    .DATA_W    (DW),
    .STOP_BITS (1),
    .MSB_FIRST (1'b0)
  ) dut (
    .clk        (clk),
    .reset_sync (reset_sync),
    .tick_en    (tick_en),
    .bus        (bus.slave),
    .ser_out    (ser_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tick_period = 4;
  int tick_ph = 0;
  int done_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // tick_en changes only on falling edges so it is stable at rising edges
  initial begin
    forever begin
      @(negedge clk);
      tick_ph = tick_ph + 1;
      if (tick_ph >= tick_period) tick_ph = 0;
      tick_en = (tick_ph == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    int          period;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag_timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, got no event expected one (t=%0t)", nm, $time);
  endtask

  // Advance to the next rising edge that carries a tick, then step 1 time unit.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 64; g++) begin
      @(posedge clk);
      if (tick_en) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    if (!seen) flag_timeout("wait_tick");
  endtask

  task automatic wait_start(output int sc);
    bit seen;
    seen = 1'b0;
    sc = 0;
    for (int g = 0; g < 40; g++) begin
      wait_tick();
      if (ser_out === 1'b0) begin
        seen = 1'b1;
        sc = cyc;
        break;
      end
    end
    if (!seen) flag_timeout("start_bit");
  endtask

  task automatic capture(output logic [15:0] bits, output int sc);
    bits = '0;
    wait_start(sc);
    bits[0] = ser_out;
    for (int i = 1; i < NBITS; i++) begin
      wait_tick();
      bits[i] = ser_out;
    end
  endtask

  // Present a word and return 1 time unit after the accept edge.
  task automatic send(input logic [7:0] d, input bit hold);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.data_in = d;
    bus.load_valid = 1'b1;
    for (int g = 0; g < 200; g++) begin
      if (bus.load_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) flag_timeout("load_ready");
    @(posedge clk);
    #1;
    if (!hold) bus.load_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] bits;
    int sc;
    int dc0;
    dc0 = done_cnt;
    tick_period = v.period;
    send(v.data, 1'b0);
    check($sformatf("vec%0d_busy_after_accept", idx), busy, 1);
    capture(bits, sc);
    check($sformatf("vec%0d_frame", idx), bits, v.exp);
    check($sformatf("vec%0d_ready_in_frame", idx), bus.load_ready, 0);
    wait_tick();
    check($sformatf("vec%0d_done_pulse", idx), done, 1);
    check($sformatf("vec%0d_ready_back", idx), bus.load_ready, 1);
    check($sformatf("vec%0d_busy_clear", idx), busy, 0);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_done_low", idx), done, 0);
    check($sformatf("vec%0d_done_count", idx), done_cnt - dc0, 1);
  endtask

  initial begin
    logic [15:0] bits;
    int sc;
    int sc2;
    int dc0;
    int done_cyc;

    bus.data_in = '0;
    bus.load_valid = 1'b0;

    vecs[0] = '{data: 8'hA5, period: 4, exp: EXP_A5};
    vecs[1] = '{data: 8'h01, period: 4, exp: EXP_01};
    vecs[2] = '{data: 8'h00, period: 4, exp: EXP_00};
    vecs[3] = '{data: 8'hFF, period: 2, exp: EXP_FF};
    vecs[4] = '{data: 8'h80, period: 3, exp: EXP_80};
    vecs[5] = '{data: 8'h3C, period: 1, exp: EXP_3C};
    vecs[6] = '{data: 8'hC3, period: 4, exp: EXP_C3};

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    #1;
    check("reset_ser_out", ser_out, 1);
    check("reset_load_ready", bus.load_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ser_out", ser_out, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back frames with load_valid held and a tick on every clock
    tick_period = 1;
    dc0 = done_cnt;
    send(8'h3C, 1'b1);
    bus.data_in = 8'hC3;
    capture(bits, sc);
    check("b2b_frame1", bits, EXP_3C);
    wait_tick();
    check("b2b_done1", done, 1);
    done_cyc = cyc;
    wait_tick();
    check("b2b_accept2", bus.load_ready, 0);
    bus.load_valid = 1'b0;
    capture(bits, sc2);
    check("b2b_start_gap", sc2 - done_cyc, 2);
    check("b2b_frame2", bits, EXP_C3);
    wait_tick();
    check("b2b_done2", done, 1);
    @(posedge clk);
    #1;
    check("b2b_done_count", done_cnt - dc0, 2);

    // Reset during data bit 4 aborts the frame
    tick_period = 4;
    send(8'h00, 1'b0);
    wait_start(sc);
    for (int i = 0; i < 5; i++) wait_tick();
    check("abort_mid_data_low", ser_out, 0);
    dc0 = done_cnt;
    reset_sync = 1'b1;
    @(posedge clk);
    #1;
    reset_sync = 1'b0;
    check("abort_ser_out", ser_out, 1);
    check("abort_load_ready", bus.load_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_line_idle", ser_out, 1);

    // load_valid toggled with 8'hFF while an 8'h00 frame is in flight
    dc0 = done_cnt;
    send(8'h00, 1'b0);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          bus.data_in = 8'hFF;
          bus.load_valid = ~bus.load_valid;
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
      end
      begin
        capture(bits, sc);
      end
    join
    check("ignore_frame", bits, EXP_00);
    wait_tick();
    check("ignore_done", done, 1);
    repeat (20) @(posedge clk);
    #1;
    check("ignore_done_count", done_cnt - dc0, 1);
    check("ignore_idle_ready", bus.load_ready, 1);
    check("ignore_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
